bitserial_adder: RTL and testbench

- Bit-serial add/subtract engine built around the one-bit full-adder cell (A, B, CI -> Q, CO), with a registered carry fed back into CI.
- Consumes two parallel WIDTH-bit operands, shifts them LSB-first through the cell over WIDTH clocks, and reassembles the parallel result.
- Serves as the sequencing stage that drives the full-adder cell in area-critical arithmetic paths, such as DSP address stepping and blitter counters.

---
 rtl/bitserial_adder.sv | 98 +++++++++
 tb/tb_bitserial_adder.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/bitserial_adder.sv
// bitserial_adder: LSB-first bit-serial add/subtract around a single full-adder cell.
//   Ports: CLK clock; RESETL async active-low reset; START request (taken only while idle);
//   SUB 0=A+B 1=A-B; OPA/OPB operands; BUSY shift in progress; DONE one-cycle result pulse;
//   SUM result register; COUT final carry (subtract: 1 = no borrow); OVF signed overflow.
//   Optional BSADD_ACCUM_EN adds ACC: when set with START, A loads from SUM for running accumulation.
module bitserial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESETL,
  input  logic             START,
  input  logic             SUB,
  input  logic [WIDTH-1:0] OPA,
  input  logic [WIDTH-1:0] OPB,
`ifdef BSADD_ACCUM_EN
  input  logic             ACC,
`endif
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OVF
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] a_sr, a_n, b_sr, b_n, sum_r, sum_n, a_load;
  logic [CW-1:0] count, count_n;
  logic carry, carry_n, cout_r, cout_n, ovf_r, ovf_n, done_r, done_n, q, co;
  assign q  = a_sr[0] ^ b_sr[0] ^ carry;
  assign co = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
`ifdef BSADD_ACCUM_EN
  assign a_load = ACC ? sum_r : OPA;
`else
  assign a_load = OPA;
`endif
  always_comb begin
    state_n = state;
    a_n     = a_sr;
    b_n     = b_sr;
    carry_n = carry;
    count_n = count;
    sum_n   = sum_r;
    cout_n  = cout_r;
    ovf_n   = ovf_r;
    done_n  = 1'b0;
    if (state == IDLE) begin
      if (START) begin
        a_n     = a_load;
        b_n     = SUB ? ~OPB : OPB;
        carry_n = SUB;
        count_n = '0;
        state_n = SHIFT;
      end
    end else begin
      sum_n   = {q, sum_r[WIDTH-1:1]};
      a_n     = a_sr >> 1;
      b_n     = b_sr >> 1;
      carry_n = co;
      count_n = count + 1'b1;
      if (count == CW'(WIDTH - 1)) begin
        cout_n  = co;
        ovf_n   = carry ^ co;
        done_n  = 1'b1;
        count_n = '0;
        state_n = IDLE;
      end
    end
  end
  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      carry  <= 1'b0;
      count  <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_n;
      a_sr   <= a_n;
      b_sr   <= b_n;
      carry  <= carry_n;
      count  <= count_n;
      sum_r  <= sum_n;
      cout_r <= cout_n;
      ovf_r  <= ovf_n;
      done_r <= done_n;
    end
  end
  assign BUSY = (state == SHIFT);
  assign DONE = done_r;
  assign SUM  = sum_r;
  assign COUT = cout_r;
  assign OVF  = ovf_r;
endmodule

// File: tb/tb_bitserial_adder.sv
// tb_bitserial_adder: directed and random checks of bitserial_adder against an arithmetic model.
module tb_bitserial_adder;
  logic CLK = 1'b0, RESETL = 1'b0, START = 1'b0, SUB = 1'b0, ACC = 1'b0;
  logic [7:0] OPA = '0, OPB = '0, SUM;
  logic BUSY, DONE, COUT, OVF;
  int checks = 0, errors = 0;
  logic [7:0] acc_sum = '0;
  always #5 CLK = ~CLK;
  bitserial_adder #(.WIDTH(8)) dut (
    .CLK(CLK), .RESETL(RESETL), .START(START), .SUB(SUB), .OPA(OPA), .OPB(OPB),
`ifdef BSADD_ACCUM_EN
    .ACC(ACC),
`endif
    .BUSY(BUSY), .DONE(DONE), .SUM(SUM), .COUT(COUT), .OVF(OVF)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic wait_done(output int n, output int busy_n);
    n = 0;
    busy_n = 0;
    do begin
      @(posedge CLK);
      #1;
      n++;
      if (!DONE && BUSY) busy_n++;
    end while (!DONE && n < 20);
  endtask
  task automatic run_op(input string tag, input logic sub, input logic acc_i,
                        input logic [7:0] a, input logic [7:0] b);
    logic [7:0] ea, es;
    logic ec, eo;
    int sa, sb, sr, n, bn;
    ea = acc_i ? acc_sum : a;
    sa = int'($signed(ea));
    sb = int'($signed(b));
    if (sub) begin
      es = ea - b;
      ec = (ea >= b);
      sr = sa - sb;
    end else begin
      es = ea + b;
      ec = (int'(ea) + int'(b)) > 255;
      sr = sa + sb;
    end
    eo = (sr > 127) || (sr < -128);
    START = 1'b1; SUB = sub; ACC = acc_i; OPA = a; OPB = b;
    @(posedge CLK);
    #1 START = 1'b0;
    check({tag, "/busy_e0"}, 32'(BUSY), 1);
    wait_done(n, bn);
    check({tag, "/latency"}, n, 8);
    check({tag, "/busy_cycles"}, bn + 1, 8);
    check({tag, "/busy_at_done"}, 32'(BUSY), 0);
    check({tag, "/sum"}, 32'(SUM), 32'(es));
    check({tag, "/cout"}, 32'(COUT), 32'(ec));
    check({tag, "/ovf"}, 32'(OVF), 32'(eo));
    acc_sum = es;
    @(posedge CLK);
    #1;
    check({tag, "/done_pulse"}, 32'(DONE), 0);
  endtask
  initial begin
    int n, bn, dones;
    #1;
    check("reset/sum", 32'(SUM), 0);
    check("reset/flags", {BUSY, DONE, COUT, OVF}, 0);
    #13 RESETL = 1'b1;
    @(posedge CLK);
    #1;
    run_op("tp_add", 0, 0, 8'h35, 8'h4A);
    check("tp_add/lit", {COUT, OVF, SUM}, 10'h07F);
    run_op("tp_ovf", 0, 0, 8'h7F, 8'h01);
    check("tp_ovf/lit", {COUT, OVF, SUM}, 10'h180);
    run_op("tp_wrap", 0, 0, 8'hFF, 8'h01);
    check("tp_wrap/lit", {COUT, OVF, SUM}, 10'h200);
    run_op("tp_sub_neg", 1, 0, 8'h10, 8'h20);
    check("tp_sub_neg/lit", {COUT, SUM}, 9'h0F0);
    run_op("tp_sub_pos", 1, 0, 8'h20, 8'h10);
    check("tp_sub_pos/lit", {COUT, OVF, SUM}, 10'h210);
    run_op("tp_sub_zero", 1, 0, 8'hA7, 8'h00);
    check("tp_sub_zero/lit", {COUT, SUM}, 9'h1A7);
    START = 1'b1; SUB = 1'b0; ACC = 1'b0; OPA = 8'h01; OPB = 8'h02;
    @(posedge CLK);
    #1 START = 1'b0;
    repeat (2) @(posedge CLK);
    #1 START = 1'b1; OPA = 8'h11; OPB = 8'h22;
    @(posedge CLK);
    #1 START = 1'b0; OPA = 8'h00; OPB = 8'h00;
    wait_done(n, bn);
    check("b2b/first_done", 32'(DONE), 1);
    check("b2b/first_sum", 32'(SUM), 32'h03);
    START = 1'b1; OPA = 8'h11; OPB = 8'h22;
    @(posedge CLK);
    #1 START = 1'b0;
    check("b2b/accepted", 32'(BUSY), 1);
    wait_done(n, bn);
    check("b2b/latency", n, 8);
    check("b2b/second_sum", 32'(SUM), 32'h33);
    @(posedge CLK);
    #1;
    START = 1'b1; SUB = 1'b0; OPA = 8'h5A; OPB = 8'hC3;
    @(posedge CLK);
    #1 START = 1'b0;
    repeat (3) @(posedge CLK);
    #2 RESETL = 1'b0;
    #1;
    check("abort/sum", 32'(SUM), 0);
    check("abort/flags", {BUSY, DONE, COUT, OVF}, 0);
    @(negedge CLK) RESETL = 1'b1;
    acc_sum = '0;
    dones = 0;
    repeat (12) begin
      @(posedge CLK);
      #1;
      if (DONE || BUSY) dones++;
    end
    check("abort/no_done", dones, 0);
`ifdef BSADD_ACCUM_EN
    run_op("acc1", 0, 1, 8'hEE, 8'h05);
    check("acc1/lit", 32'(SUM), 32'h05);
    run_op("acc2", 0, 1, 8'hEE, 8'h05);
    check("acc2/lit", 32'(SUM), 32'h0A);
    run_op("acc3", 0, 1, 8'hEE, 8'h05);
    check("acc3/lit", 32'(SUM), 32'h0F);
    run_op("acc_sub", 1, 1, 8'hEE, 8'h10);
    check("acc_sub/lit", {COUT, SUM}, 9'h0FF);
`endif
    run_op("after_abort", 0, 0, 8'h12, 8'h34);
    check("after_abort/lit", 32'(SUM), 32'h46);
    for (int i = 0; i < 40; i++) begin
`ifdef BSADD_ACCUM_EN
      run_op("rand", 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
`else
      run_op("rand", 1'($urandom), 1'b0, 8'($urandom), 8'($urandom));
`endif
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
